muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV64M multiply/divide unit in the execute stage. It is fed the forwarded operands that decode resolves (srca, and srcb from the extender/forwarding path) together with a decoded M-extension opcode. It computes over multiple cycles while asserting busy, so the pipeline control stalls fetch/decode/execute. It presents a one-cycle done pulse with a 64-bit result, which the EX/MEM register captures.

## Interface
Parameters:
- XLEN, 64, operand/result width; only 64 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- valid_i  in  1  request present this cycle.
- ready_o  out  1  unit can accept; high only in IDLE.
- op_i  in  4  0 MUL, 1 MULW, 2 DIV, 3 DIVU, 4 REM, 5 REMU, 6 DIVW, 7 DIVUW, 8 REMW, 9 REMUW; 10-15 reserved.
- a_i  in  64  rs1 operand (forwarded).
- b_i  in  64  rs2 operand (forwarded srcb).
- flush_i  in  1  synchronous abort of any in-flight operation.
- busy_o  out  1  high in MUL/DIV/DONE states; drives the pipeline stall.
- done_o  out  1  one-cycle pulse; result_o is valid while this is high.
- result_o  out  64  final result; held stable from DONE until the next accept.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Accept occurs when valid_i & ready_o & !flush_i are high at a rising edge. At accept, operands, op, sign flags and the iteration counter are latched.
- Operand prep for W ops (1, 6-9):
  - Signed ops sign-extend bit 31 of the inputs.
  - Unsigned ops zero-extend bit 31.
  - The iteration count N is 32.
- Operand prep for 64-bit ops: N = 64.
- Multiply (MUL, MULW):
  - Shift-add, one multiplier bit per cycle, LSB first.
  - The low 64 bits of the product are kept, so sign handling is unnecessary (two's complement low half).
- Divide/remainder:
  - Restoring radix-2 on magnitudes, one quotient bit per cycle.
  - Signed ops take the absolute values first.
  - Final fixup in the transition to DONE: quotient negated if sign(a) XOR sign(b); remainder negated if sign(a).
- Special cases are resolved at accept, so the unit goes directly to DONE with no iterations:
  - Divide by zero (divisor, after W extension, equals 0): quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative for the width, divisor = -1): quotient = dividend; remainder = 0.
  - Reserved op: result = 0.
- W-op result: bit 31 of the 32-bit result is sign-extended to 64 bits. This applies to both signed and unsigned W ops.
- Transitions:
  - IDLE -> MUL or DIV on accept.
  - IDLE -> DONE on accept of a special case.
  - MUL/DIV -> DONE when the counter reaches 0 (after N iterations).
  - DONE -> IDLE unconditionally.
- Flush: any state -> IDLE on the next edge. No done pulse is produced for the aborted operation, and result_o keeps its previous value.

## Timing
- Reset (resetn low, asynchronous): state IDLE, ready_o 1, busy_o 0, done_o 0, result_o 0, counter 0. Reset mid-operation discards the operation immediately.
- Accept sampled at the end of cycle T:
  - 64-bit MUL/DIV/REM: busy in cycles T+1..T+65; done_o in T+65; ready_o again in T+66.
  - W ops: done_o in T+33; ready_o in T+34.
  - Special case or reserved op: done_o in T+1; ready_o in T+2.
- busy_o = !ready_o at all times. busy_o is high in the DONE cycle, so the consumer latches result_o in that cycle while the pipeline is still stalled.
- valid_i during busy is ignored. No queueing; upstream holds the instruction because of the stall.
- flush_i and valid_i in the same IDLE cycle: flush wins and nothing is accepted.
- flush_i in the DONE cycle: done_o still reads 1 in that cycle (combinational from state), and the consumer is responsible for discarding it. The next state is IDLE.
- No combinational path from a_i/b_i/op_i to any output.

## Test plan
- MUL a=7, b=0xFFFFFFFFFFFFFFFD (-3), accept at T -> done_o only in T+65, result 0xFFFFFFFFFFFFFFEB; busy_o high T+1..T+65.
- DIV a=100, b=0 -> done_o at T+1, result 0xFFFFFFFFFFFFFFFF. REM with the same operands -> 100.
- DIVW a=0x0000000080000000, b=0xFFFFFFFFFFFFFFFF -> done at T+1, result 0xFFFFFFFF80000000. REMW with the same operands -> 0.
- REM a=-7, b=2 -> result 0xFFFFFFFFFFFFFFFF (-1). DIVUW a=0xFFFFFFFF, b=2 -> done at T+33, result 0x000000007FFFFFFF.
- DIVU a=1000, b=7, flush_i pulsed at T+10 -> IDLE at T+11, ready_o 1, no done pulse, result_o unchanged. A new MUL 3*5 then yields 15.
- MUL in flight, resetn low at T+20 -> all outputs at reset values immediately. After release, valid_i with op=12 -> done at T'+1, result 0.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV64M multiply/divide unit for the execute stage.
//               Multiplies by shift-add (one multiplier bit per cycle) and
//               divides by restoring radix-2 on operand magnitudes (one
//               quotient bit per cycle). Divide-by-zero, signed overflow and
//               reserved opcodes finish in one cycle without iterating.
// Ports       : clk       - clock, rising edge
//               resetn    - asynchronous active-low reset
//               valid_i   - request present this cycle
//               ready_o   - unit idle and able to accept
//               op_i      - M-extension opcode (0..9, 10..15 reserved)
//               a_i, b_i  - rs1 / rs2 operands
//               flush_i   - synchronous abort of any in-flight operation
//               busy_o    - stall request (MUL/DIV/DONE)
//               done_o    - one-cycle completion pulse
//               result_o  - result, stable from DONE until the next accept
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int c_CW = $clog2(XLEN) + 1;

  localparam logic [3:0] c_OP_MUL   = 4'd0;
  localparam logic [3:0] c_OP_MULW  = 4'd1;
  localparam logic [3:0] c_OP_DIV   = 4'd2;
  localparam logic [3:0] c_OP_DIVU  = 4'd3;
  localparam logic [3:0] c_OP_REM   = 4'd4;
  localparam logic [3:0] c_OP_REMU  = 4'd5;
  localparam logic [3:0] c_OP_DIVW  = 4'd6;
  localparam logic [3:0] c_OP_DIVUW = 4'd7;
  localparam logic [3:0] c_OP_REMW  = 4'd8;
  localparam logic [3:0] c_OP_REMUW = 4'd9;

  localparam logic [XLEN-1:0] c_MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  // Most-negative 32-bit value after sign extension to XLEN
  localparam logic [XLEN-1:0] c_MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_CW-1:0] r_cnt;
  logic [XLEN-1:0] r_acc;     // product accumulator / partial remainder
  logic [XLEN-1:0] r_opa;     // shifting multiplicand / dividend-quotient
  logic [XLEN-1:0] r_opb;     // shifting multiplier / divisor magnitude
  logic            r_is_w;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_result;

  // ---------------------------------------------------------------------------
  // Opcode decode (only feeds registers, never an output directly)
  // ---------------------------------------------------------------------------
  logic w_is_mul;
  logic w_is_w;
  logic w_is_rem;
  logic w_signed;
  logic w_reserved;

  always_comb begin
    w_is_mul   = 1'b0;
    w_is_w     = 1'b0;
    w_is_rem   = 1'b0;
    w_signed   = 1'b0;
    w_reserved = 1'b0;
    case (op_i)
      c_OP_MUL:   w_is_mul = 1'b1;
      c_OP_MULW:  begin w_is_mul = 1'b1; w_is_w = 1'b1; end
      c_OP_DIV:   w_signed = 1'b1;
      c_OP_DIVU:  begin end
      c_OP_REM:   begin w_signed = 1'b1; w_is_rem = 1'b1; end
      c_OP_REMU:  w_is_rem = 1'b1;
      c_OP_DIVW:  begin w_signed = 1'b1; w_is_w = 1'b1; end
      c_OP_DIVUW: w_is_w = 1'b1;
      c_OP_REMW:  begin w_signed = 1'b1; w_is_w = 1'b1; w_is_rem = 1'b1; end
      c_OP_REMUW: begin w_is_w = 1'b1; w_is_rem = 1'b1; end
      default:    w_reserved = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand preparation at accept
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] w_a_ext;
  logic [XLEN-1:0] w_b_ext;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_raw;
  logic [XLEN-1:0] w_special_res;
  logic            w_accept;

  assign w_a_ext = w_is_w ? {{(XLEN-32){w_signed & a_i[31]}}, a_i[31:0]} : a_i;
  assign w_b_ext = w_is_w ? {{(XLEN-32){w_signed & b_i[31]}}, b_i[31:0]} : b_i;

  assign w_sa    = w_signed & w_a_ext[XLEN-1];
  assign w_sb    = w_signed & w_b_ext[XLEN-1];
  assign w_a_mag = w_sa ? -w_a_ext : w_a_ext;
  assign w_b_mag = w_sb ? -w_b_ext : w_b_ext;

  assign w_div_zero = (w_b_ext == '0);
  assign w_ovf      = w_signed & (w_b_ext == '1) &
                      (w_a_ext == (w_is_w ? c_MIN_W : c_MIN_X));
  assign w_special  = w_reserved | (~w_is_mul & (w_div_zero | w_ovf));

  always_comb begin
    w_special_raw = '0;
    if (w_reserved) begin
      w_special_raw = '0;
    end else if (w_div_zero) begin
      w_special_raw = w_is_rem ? w_a_ext : '1;
    end else begin
      w_special_raw = w_is_rem ? '0 : w_a_ext;
    end
  end

  assign w_special_res = w_is_w ? {{(XLEN-32){w_special_raw[31]}}, w_special_raw[31:0]}
                                : w_special_raw;

  assign w_accept = valid_i & ready_o & ~flush_i;

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] w_mul_acc;
  logic [XLEN-1:0] w_mul_res;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_rem_sub;
  logic            w_qbit;
  logic [XLEN-1:0] w_div_rem;
  logic [XLEN-1:0] w_div_quo;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_div_raw;
  logic [XLEN-1:0] w_div_res;
  logic            w_last;

  assign w_mul_acc = r_acc + (r_opb[0] ? r_opa : '0);
  assign w_mul_res = r_is_w ? {{(XLEN-32){w_mul_acc[31]}}, w_mul_acc[31:0]} : w_mul_acc;

  // Partial remainder is one bit wider so a divisor with its MSB set still
  // compares correctly after the left shift.
  assign w_rem_sh  = {r_acc, r_opa[XLEN-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_opb};
  assign w_qbit    = ~w_rem_sub[XLEN];
  assign w_div_rem = w_qbit ? w_rem_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_div_quo = {r_opa[XLEN-2:0], w_qbit};

  // For W ops only the low 32 bits matter; negation is correct modulo 2^32.
  assign w_q_fix   = r_neg_q ? -w_div_quo : w_div_quo;
  assign w_r_fix   = r_neg_r ? -w_div_rem : w_div_rem;
  assign w_div_raw = r_is_rem ? w_r_fix : w_q_fix;
  assign w_div_res = r_is_w ? {{(XLEN-32){w_div_raw[31]}}, w_div_raw[31:0]} : w_div_raw;

  assign w_last = (r_cnt == c_CW'(1));

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_special) begin
            w_state_nxt = S_DONE;
          end else if (w_is_mul) begin
            w_state_nxt = S_MUL;
          end else begin
            w_state_nxt = S_DIV;
          end
        end
      end
      S_MUL:   if (w_last) w_state_nxt = S_DONE;
      S_DIV:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_is_w   <= 1'b0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (flush_i) begin
      // Aborted work is dropped; r_result keeps the last completed value.
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_w   <= w_is_w;
            r_is_rem <= w_is_rem;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_acc    <= '0;
            if (w_special) begin
              r_cnt    <= '0;
              r_result <= w_special_res;
            end else begin
              r_cnt <= w_is_w ? c_CW'(32) : c_CW'(XLEN);
              if (w_is_mul) begin
                r_opa <= w_a_ext;
                r_opb <= w_b_ext;
              end else begin
                // W dividends sit in the top half so the MSB feeding the
                // remainder is always r_opa[XLEN-1].
                r_opa <= w_is_w ? {w_a_mag[31:0], {(XLEN-32){1'b0}}} : w_a_mag;
                r_opb <= w_b_mag;
              end
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_opa <= {r_opa[XLEN-2:0], 1'b0};
          r_opb <= {1'b0, r_opb[XLEN-1:1]};
          r_cnt <= r_cnt - c_CW'(1);
          if (w_last) begin
            r_result <= w_mul_res;
          end
        end
        S_DIV: begin
          r_acc <= w_div_rem;
          r_opa <= w_div_quo;
          r_cnt <= r_cnt - c_CW'(1);
          if (w_last) begin
            r_result <= w_div_res;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all from registers)
  // ---------------------------------------------------------------------------
  assign ready_o  = (r_state == S_IDLE);
  assign busy_o   = ~ready_o;
  assign done_o   = (r_state == S_DONE);
  assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Directed cases, flush
//               and reset scenarios, and randomized operations compared
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk;
  logic        resetn;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  op_i;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] result_o;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(64)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Reference model: RV64M semantics in plain integer arithmetic
  // --------------------------------------------------------------------------
  function automatic logic [63:0] sext32(input logic [31:0] v);
    int     t;
    longint l;
    t = v;
    l = t;
    return l;
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] op,
                                             input logic [63:0] a,
                                             input logic [63:0] b);
    longint      sa, sb, sq;
    int          sa32, sb32, sq32;
    logic [31:0] ua32, ub32;
    logic [63:0] r;
    sa = a; sb = b;
    ua32 = a[31:0]; ub32 = b[31:0];
    sa32 = ua32; sb32 = ub32;
    r = 64'd0;
    case (op)
      4'd0: r = a * b;
      4'd1: r = sext32(ua32 * ub32);
      4'd2: begin
        if (b == 0) r = '1;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
        else begin sq = sa / sb; r = sq; end
      end
      4'd3: begin
        if (b == 0) r = '1; else r = a / b;
      end
      4'd4: begin
        if (b == 0) r = a;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = 64'd0;
        else begin sq = sa % sb; r = sq; end
      end
      4'd5: begin
        if (b == 0) r = a; else r = a % b;
      end
      4'd6: begin
        if (ub32 == 0) r = '1;
        else if (ua32 == 32'h8000_0000 && ub32 == '1) r = sext32(ua32);
        else begin sq32 = sa32 / sb32; r = sext32(sq32); end
      end
      4'd7: begin
        if (ub32 == 0) r = '1; else r = sext32(ua32 / ub32);
      end
      4'd8: begin
        if (ub32 == 0) r = sext32(ua32);
        else if (ua32 == 32'h8000_0000 && ub32 == '1) r = 64'd0;
        else begin sq32 = sa32 % sb32; r = sext32(sq32); end
      end
      4'd9: begin
        if (ub32 == 0) r = sext32(ua32); else r = sext32(ua32 % ub32);
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Cycles from the accept edge to the done cycle
  function automatic int ref_latency(input logic [3:0] op,
                                     input logic [63:0] a,
                                     input logic [63:0] b);
    if (op > 4'd9) return 1;
    if (op == 4'd0) return 65;
    if (op == 4'd1) return 33;
    if (op >= 4'd6) begin
      if (b[31:0] == 32'd0) return 1;
      if ((op == 4'd6 || op == 4'd8) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
        return 1;
      return 33;
    end
    if (b == 64'd0) return 1;
    if ((op == 4'd2 || op == 4'd4) && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return 65;
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return {32'd0, $urandom};
      6: return {32'hFFFF_FFFF, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Driver: call right after a falling edge. Issues one request, keeps
  // junk requests on the inputs while busy, and returns the result sampled
  // in the done cycle, the latency (-1 on timeout) and whether the
  // busy/ready/done handshake stayed consistent. Returns at the falling edge
  // of the first idle cycle after done.
  // --------------------------------------------------------------------------
  task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat, output bit hs_ok);
    int          guard;
    logic [31:0] t;
    hs_ok = 1'b1;
    guard = 0;
    while (!ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    @(negedge clk);
    t = $urandom;
    op_i = t[3:0];
    a_i  = {$urandom, $urandom};
    b_i  = {$urandom, $urandom};
    lat  = 1;
    while (!done_o && lat < 200) begin
      if (!busy_o || ready_o) hs_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!done_o) lat = -1;
    res = result_o;
    if (!busy_o || ready_o) hs_ok = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    if (!ready_o || busy_o || done_o || result_o !== res) hs_ok = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    resetn = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    op_i = 4'd0; a_i = 64'd0; b_i = 64'd0;
    repeat (3) @(negedge clk);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
    checks++; if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result got %h exp 0", result_o); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [3:0]  dop  [7] = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd4, 4'd7};
    logic [63:0] da   [7] = '{64'd7, 64'd100, 64'd100, 64'h0000_0000_8000_0000,
                              64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFF9,
                              64'h0000_0000_FFFF_FFFF};
    logic [63:0] db   [7] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 64'd0, '1, '1, 64'd2, 64'd2};
    logic [63:0] dres [7] = '{64'hFFFF_FFFF_FFFF_FFEB, '1, 64'd100, 64'hFFFF_FFFF_8000_0000,
                              64'd0, '1, 64'h0000_0000_7FFF_FFFF};
    int          dlat [7] = '{65, 1, 1, 1, 1, 65, 33};
    logic [63:0] res;
    int          lat;
    bit          hs;
    for (int i = 0; i < 7; i++) begin
      do_op(dop[i], da[i], db[i], res, lat, hs);
      checks++; if (res !== dres[i]) begin errors++; $display("FAIL directed_result[%0d] got %h exp %h", i, res, dres[i]); end
      checks++; if (lat !== dlat[i]) begin errors++; $display("FAIL directed_latency[%0d] got %0d exp %0d", i, lat, dlat[i]); end
      checks++; if (hs !== 1'b1) begin errors++; $display("FAIL directed_handshake[%0d] got %b exp 1", i, hs); end
    end
  endtask

  task automatic test_flush();
    logic [63:0] res;
    int          lat;
    bit          hs;
    int          pulses;
    do_op(4'd0, 64'd6, 64'd7, res, lat, hs);
    checks++; if (res !== 64'd42) begin errors++; $display("FAIL flush_pre_result got %h exp %h", res, 64'd42); end
    // DIVU 1000/7 accepted at the end of cycle T, flushed during T+10
    op_i = 4'd3; a_i = 64'd1000; b_i = 64'd7; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy_o); end
    checks++; if (result_o !== 64'd42) begin errors++; $display("FAIL flush_result_held got %h exp %h", result_o, 64'd42); end
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      if (done_o) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_no_done got %0d exp 0", pulses); end
    do_op(4'd0, 64'd3, 64'd5, res, lat, hs);
    checks++; if (res !== 64'd15) begin errors++; $display("FAIL flush_next_mul got %h exp %h", res, 64'd15); end
    checks++; if (lat !== 65) begin errors++; $display("FAIL flush_next_latency got %0d exp 65", lat); end

    // flush and valid together in IDLE: nothing accepted
    op_i = 4'd2; a_i = 64'd100; b_i = 64'd0; valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    checks++; if (ready_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL flush_valid_same_cycle got ready=%b done=%b exp ready=1 done=0", ready_o, done_o); end
    checks++; if (result_o !== 64'd15) begin errors++; $display("FAIL flush_valid_result got %h exp %h", result_o, 64'd15); end

    // flush during DONE: pulse still visible, unit returns to IDLE
    op_i = 4'd3; a_i = 64'd8; b_i = 64'd0; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b1;
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL flush_in_done_pulse got %b exp 1", done_o); end
    checks++; if (result_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL flush_in_done_result got %h exp all-ones", result_o); end
    @(negedge clk);
    flush_i = 1'b0;
    checks++; if (ready_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL flush_in_done_idle got ready=%b done=%b exp ready=1 done=0", ready_o, done_o); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int          lat;
    bit          hs;
    op_i = 4'd0; a_i = 64'd12345; b_i = 64'd678; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (19) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL reset_mid_ctrl got ready=%b busy=%b done=%b exp 1 0 0", ready_o, busy_o, done_o); end
    checks++; if (result_o !== 64'd0) begin errors++; $display("FAIL reset_mid_result got %h exp 0", result_o); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_op(4'd12, {$urandom, $urandom}, {$urandom, $urandom}, res, lat, hs);
    checks++; if (res !== 64'd0) begin errors++; $display("FAIL reserved_result got %h exp 0", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL reserved_latency got %0d exp 1", lat); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [6] = '{4'd3, 4'd9, 4'd15, 4'd1, 4'd6, 4'd8};
    logic [63:0] a, b, res, exp;
    int          lat;
    bit          hs;
    for (int i = 0; i < 6; i++) begin
      a = rand_operand();
      b = (i % 2 == 0) ? 64'd0 : rand_operand();
      if (ops[i] == 4'd6) begin a = 64'hFFFF_FFFF_8000_0000; b = '1; end
      exp = ref_result(ops[i], a, b);
      do_op(ops[i], a, b, res, lat, hs);
      checks++; if (res !== exp) begin errors++; $display("FAIL b2b_result op=%0d a=%h b=%h got %h exp %h", ops[i], a, b, res, exp); end
      checks++; if (lat !== ref_latency(ops[i], a, b)) begin errors++; $display("FAIL b2b_latency op=%0d got %0d exp %0d", ops[i], lat, ref_latency(ops[i], a, b)); end
      checks++; if (hs !== 1'b1) begin errors++; $display("FAIL b2b_handshake op=%0d got %b exp 1", ops[i], hs); end
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    logic [3:0]  op;
    logic [63:0] a, b, res, exp;
    int          lat, elat;
    bit          hs;
    for (int i = 0; i < 60; i++) begin
      t  = $urandom;
      op = (t[7:4] == 4'hF) ? t[3:0] : 4'(t[3:0] % 10);
      a  = rand_operand();
      b  = rand_operand();
      exp  = ref_result(op, a, b);
      elat = ref_latency(op, a, b);
      do_op(op, a, b, res, lat, hs);
      checks++; if (res !== exp) begin errors++; $display("FAIL rand_result op=%0d a=%h b=%h got %h exp %h", op, a, b, res, exp); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL rand_latency op=%0d got %0d exp %0d", op, lat, elat); end
      checks++; if (hs !== 1'b1) begin errors++; $display("FAIL rand_handshake op=%0d got %b exp 1", op, hs); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
